// File: rtl/one_to_four_bus.sv
// Serial-to-parallel bus assembler: gathers single-bit lanes
// into WIDTH-bit words with a one-word buffered output handshake.
module one_to_four_bus #(
   parameter int WIDTH     = 8,
   parameter bit LSB_FIRST = 1'b1,
   localparam int CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sync,
   input  logic             bit_in,
   input  logic             bit_valid,
   output logic             bit_ready,
   output logic [WIDTH-1:0] bus_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CW-1:0]    bit_count
);

   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [WIDTH-1:0] asm_q;
   logic [WIDTH-1:0] asm_nxt;
   logic [CW-1:0]    cnt_q;
   logic [CW-1:0]    pos;
   logic [WIDTH-1:0] bus_q;
   logic             vld_q;
   logic             is_last;
   logic             accept;
   logic             done;
   logic             drain;

   assign is_last = (cnt_q == LAST);
   assign drain   = vld_q && out_ready;

   // Only the final bit of a word waits on a stalled output.
   assign bit_ready = !sync && (!is_last || !vld_q || out_ready);

   assign accept = bit_valid && bit_ready;
   assign done   = accept && is_last;

   // Target position of the incoming bit within the word.
   always_comb begin
      if (LSB_FIRST)
         pos = cnt_q;
      else
         pos = LAST - cnt_q;
   end

   // Partial word with the incoming bit merged in.
   always_comb begin
      asm_nxt = asm_q;
      if (accept)
         asm_nxt[pos] = bit_in;
   end

   // Assembly register and bit counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         asm_q <= '0;
         cnt_q <= '0;
      end else if (sync) begin
         asm_q <= '0;
         cnt_q <= '0;
      end else if (done) begin
         asm_q <= '0;
         cnt_q <= '0;
      end else if (accept) begin
         asm_q <= asm_nxt;
         cnt_q <= cnt_q + 1'b1;
      end
   end

   // Output buffer: a completed word loads even while draining.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus_q <= '0;
         vld_q <= 1'b0;
      end else if (done) begin
         bus_q <= asm_nxt;
         vld_q <= 1'b1;
      end else if (drain) begin
         vld_q <= 1'b0;
      end
   end

   assign bus_out   = bus_q;
   assign out_valid = vld_q;
   assign bit_count = cnt_q;

endmodule

// File: tb/tb_one_to_four_bus.sv
// Randomized and directed bench for one_to_four_bus, checking both
// bit orders against a queue-based reference model.
module tb_one_to_four_bus;

   localparam int W = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic sync = 1'b0;
   logic bit_in = 1'b0;
   logic bit_valid = 1'b0;
   logic out_ready = 1'b0;

   logic         l_rdy, m_rdy;
   logic [W-1:0] l_bus, m_bus;
   logic         l_vld, m_vld;
   logic [2:0]   l_cnt, m_cnt;

   int total = 0;
   int bad = 0;

   bit     part[$];
   logic   e_vld;
   logic [W-1:0] e_l, e_m;
   logic [W-1:0] got[$];

   always #5 clk = ~clk;

   one_to_four_bus #(.WIDTH(W), .LSB_FIRST(1'b1)) u_l (
      .clk(clk), .rst(rst), .sync(sync),
      .bit_in(bit_in), .bit_valid(bit_valid),
      .bit_ready(l_rdy), .bus_out(l_bus),
      .out_valid(l_vld), .out_ready(out_ready),
      .bit_count(l_cnt)
   );

   one_to_four_bus #(.WIDTH(W), .LSB_FIRST(1'b0)) u_m (
      .clk(clk), .rst(rst), .sync(sync),
      .bit_in(bit_in), .bit_valid(bit_valid),
      .bit_ready(m_rdy), .bus_out(m_bus),
      .out_valid(m_vld), .out_ready(out_ready),
      .bit_count(m_cnt)
   );

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_state();
      chk("bus_l", 32'(l_bus), 32'(e_l));
      chk("bus_m", 32'(m_bus), 32'(e_m));
      chk("vld_l", 32'(l_vld), 32'(e_vld));
      chk("vld_m", 32'(m_vld), 32'(e_vld));
      chk("cnt_l", 32'(l_cnt), part.size());
      chk("cnt_m", 32'(m_cnt), part.size());
   endtask

   task automatic model_reset();
      part.delete();
      e_vld = 1'b0;
      e_l = '0;
      e_m = '0;
   endtask

   // One clock: drive, check ready, advance model, check outputs.
   task automatic cycle(input logic s, input logic bv,
                        input logic b, input logic ordy,
                        output logic acc);
      logic rdy;
      logic drained;
      sync = s;
      bit_valid = bv;
      bit_in = b;
      out_ready = ordy;
      #1;
      rdy = !s && (part.size() != W-1 || !e_vld || ordy);
      chk("rdy_l", 32'(l_rdy), 32'(rdy));
      chk("rdy_m", 32'(m_rdy), 32'(rdy));
      acc = bv && rdy;
      drained = e_vld && ordy;
      if (drained)
         got.push_back(l_bus);
      @(posedge clk);
      if (drained)
         e_vld = 1'b0;
      if (s) begin
         part.delete();
      end else if (acc) begin
         part.push_back(b);
         if (part.size() == W) begin
            for (int i = 0; i < W; i++) begin
               e_l[i] = part[i];
               e_m[W-1-i] = part[i];
            end
            e_vld = 1'b1;
            part.delete();
         end
      end
      #1;
      chk_state();
   endtask

   task automatic send_bit(input logic b, input logic ordy);
      logic acc;
      int n;
      n = 0;
      acc = 1'b0;
      while (!acc && n < 40) begin
         cycle(1'b0, 1'b1, b, ordy, acc);
         n++;
      end
      if (!acc)
         chk("send_timeout", 32'd1, 32'd0);
   endtask

   task automatic send_word(input logic [W-1:0] w,
                            input logic ordy);
      for (int i = 0; i < W; i++)
         send_bit(w[i], ordy);
   endtask

   task automatic idle(input logic ordy);
      logic acc;
      cycle(1'b0, 1'b0, 1'b0, ordy, acc);
   endtask

   initial begin
      logic acc;
      logic [W-1:0] w;
      int base;

      model_reset();
      #2;
      chk_state();
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(1'b1);

      // bits 1,0,1,0,0,1,0,1 in arrival order
      send_word(8'hA5, 1'b1);
      chk("a5_l", 32'(l_bus), 32'hA5);
      chk("a5_m", 32'(m_bus), 32'hA5);
      chk("a5_vld", 32'(l_vld), 32'd1);
      idle(1'b1);
      chk("a5_drop", 32'(l_vld), 32'd0);

      // arrival 1,1,1,1,0,0,0,0
      send_word(8'h0F, 1'b1);
      chk("f0_m", 32'(m_bus), 32'hF0);
      chk("0f_l", 32'(l_bus), 32'h0F);
      idle(1'b1);

      // backpressure
      send_word(8'h3C, 1'b0);
      w = 8'h81;
      for (int i = 0; i < W-1; i++)
         send_bit(w[i], 1'b0);
      chk("bp_cnt", 32'(l_cnt), 32'd7);
      cycle(1'b0, 1'b1, w[7], 1'b0, acc);
      chk("bp_stall", 32'(acc), 32'd0);
      chk("bp_hold", 32'(l_bus), 32'h3C);
      base = got.size();
      cycle(1'b0, 1'b1, w[7], 1'b1, acc);
      chk("bp_acc", 32'(acc), 32'd1);
      chk("bp_got", 32'(got[base]), 32'h3C);
      chk("bp_new", 32'(l_bus), 32'h81);
      chk("bp_vld", 32'(l_vld), 32'd1);
      idle(1'b1);

      // continuous words
      base = got.size();
      send_word(8'h00, 1'b1);
      send_word(8'hFF, 1'b1);
      send_word(8'h5A, 1'b1);
      send_word(8'hC3, 1'b1);
      idle(1'b1);
      chk("cont_n", got.size() - base, 32'd4);
      chk("cont0", 32'(got[base]), 32'h00);
      chk("cont1", 32'(got[base+1]), 32'hFF);
      chk("cont2", 32'(got[base+2]), 32'h5A);
      chk("cont3", 32'(got[base+3]), 32'hC3);

      // sync with a held output word
      send_word(8'h66, 1'b0);
      for (int i = 0; i < 5; i++)
         send_bit(1'b1, 1'b0);
      cycle(1'b1, 1'b1, 1'b1, 1'b0, acc);
      chk("sync_acc", 32'(acc), 32'd0);
      chk("sync_cnt", 32'(l_cnt), 32'd0);
      chk("sync_hold", 32'(l_bus), 32'h66);
      chk("sync_vld", 32'(l_vld), 32'd1);
      idle(1'b1);
      send_word(8'hAA, 1'b1);
      chk("sync_aa", 32'(l_bus), 32'hAA);
      idle(1'b1);

      // async reset mid-word with a pending word
      send_word(8'h77, 1'b0);
      for (int i = 0; i < 3; i++)
         send_bit(1'b1, 1'b0);
      bit_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      chk_state();
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk_state();
      for (int i = 0; i < 12; i++)
         idle(1'b1);
      chk("rst_quiet", 32'(l_vld), 32'd0);
      send_word(8'h19, 1'b1);
      chk("rst_new", 32'(l_bus), 32'h19);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         cycle(($urandom_range(0, 39) == 0),
               ($urandom_range(0, 3) != 0),
               1'($urandom),
               ($urandom_range(0, 2) != 0), acc);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
